// File: rtl/dft_pin_walk_sequencer.sv
// Board-test walking-zero loopback scan: drives all-high then one low pin per step, samples synchronized sense after SETTLE_CYCLES.
// Step results land on the sampling edge; start/abort are single-cycle pulses, there is no backpressure.
module dft_pin_walk_sequencer #(
    parameter int NUM_PINS      = 20,
    parameter int SETTLE_CYCLES = 48,
    parameter int STEP_W        = 5
) (
    input  logic                clk_48mhz,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic [NUM_PINS-1:0] drive,
    input  logic [NUM_PINS-1:0] sense,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [STEP_W-1:0]   fail_step,
    output logic [NUM_PINS-1:0] fail_mask
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_PINS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [STEP_W-1:0]   step, step_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [NUM_PINS-1:0] drive_nxt;
    logic                busy_nxt, done_nxt, pass_nxt;
    logic [STEP_W-1:0]   fail_step_nxt;
    logic [NUM_PINS-1:0] fail_mask_nxt;
    logic [NUM_PINS-1:0] sense_m, sense_s;

    // Pattern for step k: all ones, with pin k-1 pulled low for k >= 1.
    function automatic logic [NUM_PINS-1:0] walk(input logic [STEP_W-1:0] k);
        logic [NUM_PINS-1:0] w;
        w = '1;
        for (int i = 0; i < NUM_PINS; i++) begin
            if (k == STEP_W'(i + 1)) w[i] = 1'b0;
        end
        return w;
    endfunction

    // Sense pins are asynchronous; idle-high matches the all-ones baseline.
    always_ff @(posedge clk_48mhz or negedge rst_n) begin
        if (!rst_n) begin
            sense_m <= '1;
            sense_s <= '1;
        end else begin
            sense_m <= sense;
            sense_s <= sense_m;
        end
    end

    always_ff @(posedge clk_48mhz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            step      <= '0;
            cnt       <= '0;
            drive     <= '1;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_step <= '0;
            fail_mask <= '0;
        end else begin
            state     <= state_nxt;
            step      <= step_nxt;
            cnt       <= cnt_nxt;
            drive     <= drive_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            fail_step <= fail_step_nxt;
            fail_mask <= fail_mask_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        step_nxt      = step;
        cnt_nxt       = cnt;
        drive_nxt     = drive;
        done_nxt      = done;
        pass_nxt      = pass;
        fail_step_nxt = fail_step;
        fail_mask_nxt = fail_mask;

        case (state)
            ST_IDLE, ST_DONE: begin
                drive_nxt = '1;
                if (start) begin
                    state_nxt     = ST_RUN;
                    step_nxt      = '0;
                    cnt_nxt       = '0;
                    done_nxt      = 1'b0;
                    pass_nxt      = 1'b0;
                    fail_step_nxt = '0;
                    fail_mask_nxt = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    drive_nxt = '1;
                end else if (cnt == CNT_LAST) begin
                    if (sense_s != drive) begin
                        state_nxt     = ST_DONE;
                        drive_nxt     = '1;
                        done_nxt      = 1'b1;
                        pass_nxt      = 1'b0;
                        fail_step_nxt = step;
                        fail_mask_nxt = sense_s ^ drive;
                    end else if (step == STEP_LAST) begin
                        state_nxt = ST_DONE;
                        drive_nxt = '1;
                        done_nxt  = 1'b1;
                        pass_nxt  = 1'b1;
                    end else begin
                        step_nxt  = step + STEP_W'(1);
                        cnt_nxt   = '0;
                        drive_nxt = walk(step + STEP_W'(1));
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                drive_nxt = '1;
            end
        endcase

        busy_nxt = (state_nxt == ST_RUN);
    end

endmodule

// File: doc/dft_pin_walk_sequencer.md
# dft_pin_walk_sequencer

Board-test sequencer for the DFT loopback image. It replaces static pin-to-pin wiring with a self-checking scan. The block drives a bank of output pins with a baseline all-high pattern, then a walking-zero pattern. After a settle delay at each step it samples the looped-back input pins and stops at the first mismatch, reporting the step and failing bits. It runs on the 48 MHz PLL clock, between the pin I/O and the slow-clock status indicator.

## Interface

Parameters:
- NUM_PINS, 20, number of drive/sense pin pairs under test
- SETTLE_CYCLES, 48, cycles per step from drive change to sample; must be ≥ 3
- STEP_W, 5, width of step index; must satisfy 2^STEP_W > NUM_PINS

Ports:
- clk_48mhz  in  1  PLL output clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a scan
- abort  in  1  single-cycle request to cancel a running scan
- drive  out  NUM_PINS  pattern driven onto the output pins
- sense  in  NUM_PINS  looped-back input pins; asynchronous to the block
- busy  out  1  scan in progress
- done  out  1  scan completed, either pass or fail; held until the next start
- pass  out  1  valid when done; 1 means no mismatch at any step
- fail_step  out  STEP_W  step at which the first mismatch occurred
- fail_mask  out  NUM_PINS  sense XOR expected, captured at the failing step

## Operation

- sense passes through a 2-flop synchronizer (sense_s) before any comparison.
- Steps:
  - Step 0 (baseline): drive = all ones.
  - Step k, for 1 ≤ k ≤ NUM_PINS: drive = all ones except bit k-1 = 0.
- Expected value at each step = drive. Mismatch = (sense_s != drive).
- States and transitions:
  - IDLE: drive = all ones, busy = 0. On start: clear done, pass, fail_step and fail_mask; step = 0; counter = 0; go to RUN.
  - RUN: busy = 1.
    - Counter increments every cycle.
    - When counter = SETTLE_CYCLES-1, sample sense_s:
      - Mismatch: fail_step = step, fail_mask = sense_s ^ drive, pass = 0, go to DONE.
      - No mismatch, step = NUM_PINS: pass = 1, go to DONE.
      - Otherwise: step + 1, counter = 0, drive updates on that same edge.
  - DONE: done = 1, busy = 0, drive = all ones. On start: behaves as from IDLE.
- abort in RUN: go to IDLE on the next edge. drive = all ones; done, pass, fail_step and fail_mask stay 0.
- abort outside RUN is ignored.
- start while in RUN is ignored.
- start and abort asserted in the same cycle while in RUN: abort wins.
- Counter width is ceil(log2(SETTLE_CYCLES)). The counter never wraps, because it is cleared on every step advance.

## Timing

- Reset values (asynchronous, on rst_n = 0): state = IDLE, drive = all ones, busy = 0, done = 0, pass = 0, fail_step = 0, fail_mask = 0, counter = 0, synchronizer flops = all ones.
- Reset asserted mid-scan returns immediately to the reset values above; no partial result is reported.
- start is sampled at edge T0. busy = 1 and step-0 drive are valid from T0+1.
- Each step lasts exactly SETTLE_CYCLES cycles. The sample uses sense_s, which reflects pins as they were 2 cycles before the sample edge.
- Full pass:
  - done = pass = 1 from edge T0 + (NUM_PINS+1)·SETTLE_CYCLES.
  - With defaults this is T0 + 1008.
- Failure at step k:
  - done = 1 from edge T0 + (k+1)·SETTLE_CYCLES.
  - busy falls on the same edge that done rises.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Ideal loopback (sense = drive) with defaults, start at T0 → busy for 1008 cycles, then done = 1, pass = 1, fail_step = 0, fail_mask = 0.
- sense[7] stuck at 0 → done at T0 + 48, pass = 0, fail_step = 0, fail_mask = 0x00080.
- sense[12] stuck at 1 (open) → fail_step = 13, fail_mask = 0x01000, done at T0 + 672.
- Pins 3 and 4 shorted (both senses = drive[3] & drive[4]) → fail_step = 4, fail_mask = 0x00010, pass = 0.
- Abort at cycle T0 + 300 → IDLE next edge, drive = 0xFFFFF, done = 0. A start pulse during the scan has no effect. A fresh start then runs the full 1008-cycle scan to pass.
- rst_n pulsed low at T0 + 500 → all outputs at reset values within the same cycle, drive = 0xFFFFF. After release, a start runs normally to pass.
